eth_rx_hdr_strip: RTL and testbench

- Receive-side stage directly downstream of the Ethernet stimulus/source. It consumes 64-bit AXI-stream Ethernet frames and checks the destination MAC.
- Accepted frames leave with the 14-byte header removed and the payload realigned to byte 0. Source MAC and ethertype travel as per-frame sideband.
- Non-matching and runt frames are discarded and counted.

---
 rtl/eth_rx_hdr_strip_pkg.sv | 40 ++++
 rtl/eth_rx_hdr_strip_sat_counter32.sv | 27 ++
 rtl/eth_rx_hdr_strip.sv | 207 ++++++++++++++++++++
 tb/tb_eth_rx_hdr_strip.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_hdr_strip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : eth_pkg                                                            |
// | Brief   : Shared constants, FSM states and byte-enable helpers for eth_rx.  |
// | Rev     : 1.0                                                               |
// +----------------------------------------------------------------------------+
package eth_pkg;

    localparam int          ETH_HDR_BYTES = 14;
    localparam logic [47:0] BCAST_MAC     = 48'hffff_ffff_ffff;

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        PAYLOAD = 3'd2,
        FLUSH   = 3'd3,
        DROP    = 3'd4
    } state_t;

    // Contiguous byte enable covering the lowest n bytes (saturates at 8).
    function automatic logic [7:0] keep_from_count(input int n);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) k[i] = 1'b1;
        end
        return k;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_hdr_strip_sat_counter32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sat_counter32                                                      |
// | Brief  : 32-bit event counter that sticks at all-ones.                      |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module sat_counter32 (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_count <= '0;
        end else if (inc && (r_count != 32'hffff_ffff)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/eth_rx_hdr_strip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : eth_rx_hdr_strip                                                   |
// | Brief  : Filters frames on destination MAC, strips the 14-byte header and  |
// |          realigns the payload to byte 0 with src MAC/ethertype sideband.   |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
module eth_rx_hdr_strip
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR     = 48'hfa163e55ca02,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter bit          PROMISC      = 1'b0
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [63:0] stream_in_DATA,
    input  logic [7:0]  stream_in_KEEP,
    input  logic        stream_in_LAST,
    input  logic        stream_in_VALID,
    output logic        stream_in_READY,
    output logic [63:0] stream_out_DATA,
    output logic [7:0]  stream_out_KEEP,
    output logic        stream_out_LAST,
    output logic        stream_out_VALID,
    input  logic        stream_out_READY,
    output logic [47:0] meta_src_mac,
    output logic [15:0] meta_ethertype,
    output logic [31:0] frames_ok_cnt,
    output logic [31:0] frames_drop_cnt
);

    // Header bytes that spill into flit 1 beyond its first 8-byte boundary.
    localparam logic [3:0] c_HDR_TAIL = 4'(ETH_HDR_BYTES - 8);

    state_t      r_state, w_state_nxt;
    logic [47:0] r_src_mac;
    logic [15:0] r_ethertype;
    logic [15:0] r_carry;
    logic [3:0]  r_resid;
    logic [63:0] r_out_data;
    logic [7:0]  r_out_keep;
    logic        r_out_last, r_out_valid;
    logic [47:0] r_meta_src;
    logic [15:0] r_meta_type;

    logic [47:0] w_dst;
    logic        w_match, w_out_free, w_rdy_state, w_in_fire;
    logic [3:0]  w_n;
    logic        w_out_load, w_ok_inc, w_drop_inc;
    logic [63:0] w_out_data;
    logic [7:0]  w_out_keep;
    logic        w_out_last;

    // Wire byte 0 is the most significant MAC byte.
    assign w_dst = {stream_in_DATA[7:0],   stream_in_DATA[15:8],  stream_in_DATA[23:16],
                    stream_in_DATA[31:24], stream_in_DATA[39:32], stream_in_DATA[47:40]};
    assign w_match = PROMISC || (w_dst == MAC_ADDR) || (ACCEPT_BCAST && (w_dst == BCAST_MAC));
    assign w_n        = popcount8(stream_in_KEEP);
    assign w_out_free = !r_out_valid || stream_out_READY;

    assign stream_in_READY = aresetn && w_rdy_state;
    assign w_in_fire       = stream_in_VALID && stream_in_READY;

    always_comb begin
        w_state_nxt = r_state;
        w_rdy_state = 1'b1;
        w_out_load  = 1'b0;
        w_ok_inc    = 1'b0;
        w_drop_inc  = 1'b0;
        w_out_data  = {stream_in_DATA[47:0], r_carry};
        w_out_keep  = 8'hff;
        w_out_last  = 1'b0;
        case (r_state)
            HDR0: begin
                if (w_in_fire) begin
                    if (stream_in_LAST)  w_drop_inc  = 1'b1;
                    else if (!w_match)   w_state_nxt = DROP;
                    else                 w_state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (w_in_fire) begin
                    if (stream_in_LAST && (w_n <= c_HDR_TAIL)) begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = HDR0;
                    end else if (stream_in_LAST) begin
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                w_rdy_state = w_out_free;
                if (w_in_fire) begin
                    w_out_load = 1'b1;
                    if (stream_in_LAST && (w_n <= c_HDR_TAIL)) begin
                        w_out_keep  = keep_from_count(int'(w_n) + 2);
                        w_out_last  = 1'b1;
                        w_ok_inc    = 1'b1;
                        w_state_nxt = HDR0;
                    end else if (stream_in_LAST) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_rdy_state = 1'b0;
                if (w_out_free) begin
                    w_out_load  = 1'b1;
                    w_out_data  = {48'h0, r_carry};
                    w_out_keep  = keep_from_count(int'(r_resid));
                    w_out_last  = 1'b1;
                    w_ok_inc    = 1'b1;
                    w_state_nxt = HDR0;
                end
            end
            DROP: begin
                if (w_in_fire && stream_in_LAST) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = HDR0;
                end
            end
            default: w_state_nxt = HDR0;
        endcase
        // Unused byte lanes leave as zero rather than stale input bytes.
        for (int i = 0; i < 8; i++) begin
            if (!w_out_keep[i]) w_out_data[8*i +: 8] = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_state <= HDR0;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_src_mac   <= '0;
            r_ethertype <= '0;
            r_carry     <= '0;
            r_resid     <= '0;
        end else if (w_in_fire) begin
            case (r_state)
                HDR0: r_src_mac[47:32] <= {stream_in_DATA[55:48], stream_in_DATA[63:56]};
                HDR1: begin
                    r_src_mac[31:0] <= {stream_in_DATA[7:0],   stream_in_DATA[15:8],
                                        stream_in_DATA[23:16], stream_in_DATA[31:24]};
                    r_ethertype     <= {stream_in_DATA[39:32], stream_in_DATA[47:40]};
                    r_carry         <= stream_in_DATA[63:48];
                    r_resid         <= w_n - c_HDR_TAIL;
                end
                PAYLOAD: begin
                    r_carry <= stream_in_DATA[63:48];
                    r_resid <= w_n - c_HDR_TAIL;
                end
                default: ;
            endcase
        end
    end

    // Meta is captured with each data flit so a following frame's header
    // parse cannot disturb sideband still waiting on the output.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_meta_src  <= '0;
            r_meta_type <= '0;
        end else if (w_out_load) begin
            r_out_data  <= w_out_data;
            r_out_keep  <= w_out_keep;
            r_out_last  <= w_out_last;
            r_out_valid <= 1'b1;
            r_meta_src  <= r_src_mac;
            r_meta_type <= r_ethertype;
        end else if (stream_out_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign stream_out_DATA  = r_out_data;
    assign stream_out_KEEP  = r_out_keep;
    assign stream_out_LAST  = r_out_last;
    assign stream_out_VALID = r_out_valid;
    assign meta_src_mac     = r_meta_src;
    assign meta_ethertype   = r_meta_type;

    sat_counter32 u_ok_cnt (
        .clk     (clk),
        .aresetn (aresetn),
        .inc     (w_ok_inc),
        .count   (frames_ok_cnt)
    );

    sat_counter32 u_drop_cnt (
        .clk     (clk),
        .aresetn (aresetn),
        .inc     (w_drop_inc),
        .count   (frames_drop_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_hdr_strip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_eth_rx_hdr_strip                                                |
// | Brief  : Directed + random frames against a byte-queue reference model.     |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_eth_rx_hdr_strip;

    localparam logic [47:0] LOCAL_MAC = 48'hfa163e55ca02;
    localparam logic [47:0] BCAST     = 48'hffff_ffff_ffff;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last, in_valid, out_ready;
    logic        in_ready, out_valid, out_last;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [31:0] ok_cnt, drop_cnt;

    logic        nb_in_ready, nb_out_valid, nb_out_last;
    logic [63:0] nb_out_data;
    logic [7:0]  nb_out_keep;
    logic [47:0] nb_src_mac;
    logic [15:0] nb_ethertype;
    logic [31:0] nb_ok_cnt, nb_drop_cnt;

    always #5 clk = ~clk;

    eth_rx_hdr_strip dut (
        .clk(clk), .aresetn(aresetn),
        .stream_in_DATA(in_data), .stream_in_KEEP(in_keep), .stream_in_LAST(in_last),
        .stream_in_VALID(in_valid), .stream_in_READY(in_ready),
        .stream_out_DATA(out_data), .stream_out_KEEP(out_keep), .stream_out_LAST(out_last),
        .stream_out_VALID(out_valid), .stream_out_READY(out_ready),
        .meta_src_mac(src_mac), .meta_ethertype(ethertype),
        .frames_ok_cnt(ok_cnt), .frames_drop_cnt(drop_cnt)
    );

    // Second instance without broadcast acceptance, fed the same traffic.
    eth_rx_hdr_strip #(.ACCEPT_BCAST(1'b0)) dut_nb (
        .clk(clk), .aresetn(aresetn),
        .stream_in_DATA(in_data), .stream_in_KEEP(in_keep), .stream_in_LAST(in_last),
        .stream_in_VALID(in_valid), .stream_in_READY(nb_in_ready),
        .stream_out_DATA(nb_out_data), .stream_out_KEEP(nb_out_keep), .stream_out_LAST(nb_out_last),
        .stream_out_VALID(nb_out_valid), .stream_out_READY(out_ready),
        .meta_src_mac(nb_src_mac), .meta_ethertype(nb_ethertype),
        .frames_ok_cnt(nb_ok_cnt), .frames_drop_cnt(nb_drop_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [47:0] src;
        logic [15:0] et;
    } oflit_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          bubbles  = 0;
    int          exp_ok = 0, exp_drop = 0, nb_exp_ok = 0, nb_exp_drop = 0;
    oflit_t      rxq[$];
    logic [7:0]  frm[$];
    bit          hold_v = 1'b0;
    logic [63:0] hold_data;
    logic [73:0] hold_side;
    bit          bp_en;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects transfers and checks stalled flits stay put.
    always @(negedge clk) begin
        if (aresetn) begin
            if (!in_ready) bubbles++;
            if (hold_v) begin
                chk("hold_data", out_data, hold_data);
                chk("hold_side", {out_valid, out_keep, out_last, ethertype, src_mac}, hold_side);
            end
            hold_v    = out_valid && !out_ready;
            hold_data = out_data;
            hold_side = {out_valid, out_keep, out_last, ethertype, src_mac};
            if (out_valid && out_ready)
                rxq.push_back('{out_data, out_keep, out_last, src_mac, ethertype});
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic send_flit(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t;
        t = 0;
        in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("in_ready_wait", in_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bit gaps);
        int          nf;
        logic [63:0] d;
        logic [7:0]  k;
        nf = (frm.size() + 7) / 8;
        for (int f = 0; f < nf; f++) begin
            d = '0; k = '0;
            for (int b = 0; b < 8; b++) begin
                if (f*8 + b < frm.size()) begin
                    d[8*b +: 8] = frm[f*8 + b];
                    k[b] = 1'b1;
                end
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send_flit(d, k, f == nf - 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] et, input int plen, input bit seq);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(seq ? 8'(i) : 8'($urandom));
    endtask

    // Reference: a frame longer than the header with a wanted dst MAC yields
    // its payload bytes in 8-byte chunks; anything else is a counted drop.
    task automatic run_frame(input bit gaps);
        int          L, P, t;
        logic [47:0] dst;
        bit          acc, acc_nb;
        oflit_t      exq[$];
        oflit_t      e, r;
        logic [63:0] kmask;
        L   = frm.size();
        dst = '0;
        if (L >= 6) dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        acc    = (L > 14) && (dst == LOCAL_MAC || dst == BCAST);
        acc_nb = (L > 14) && (dst == LOCAL_MAC);
        if (acc) begin
            P = L - 14;
            for (int o = 0; o*8 < P; o++) begin
                e.data = '0; e.keep = '0;
                for (int b = 0; b < 8; b++) begin
                    if (o*8 + b < P) begin
                        e.data[8*b +: 8] = frm[14 + o*8 + b];
                        e.keep[b] = 1'b1;
                    end
                end
                e.last = (o*8 + 8 >= P);
                e.src  = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
                e.et   = {frm[12], frm[13]};
                exq.push_back(e);
            end
        end
        send_frame(gaps);
        t = 0;
        while (rxq.size() < exq.size() && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("flit_count", rxq.size(), exq.size());
        while (rxq.size() > 0 && exq.size() > 0) begin
            r = rxq.pop_front();
            e = exq.pop_front();
            kmask = '0;
            for (int b = 0; b < 8; b++) if (e.keep[b]) kmask[8*b +: 8] = 8'hff;
            chk("out_data", r.data & kmask, e.data);
            chk("out_keep_last", {r.keep, r.last}, {e.keep, e.last});
            chk("out_meta", {r.src, r.et}, {e.src, e.et});
        end
        rxq.delete();
        if (acc) exp_ok++; else exp_drop++;
        if (acc_nb) nb_exp_ok++; else nb_exp_drop++;
        chk("ok_cnt", ok_cnt, exp_ok);
        chk("drop_cnt", drop_cnt, exp_drop);
        chk("nb_cnts", {nb_ok_cnt, nb_drop_cnt}, {32'(nb_exp_ok), 32'(nb_exp_drop)});
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        int          L;
        aresetn = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {out_valid, out_data, out_keep, out_last}, '0);
        chk("reset_meta_cnt", {src_mac, ethertype, ok_cnt, drop_cnt}, '0);
        chk("reset_in_ready", in_ready, 1'b0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // Reference 30-byte frame: two full output flits, no flush bubble.
        bubbles = 0;
        build_frame(LOCAL_MAC, 48'h0cc47a88c047, 16'h0800, 16, 1'b1);
        run_frame(1'b0);
        chk("no_bubble", bubbles, 0);

        // Foreign dst dropped, then the same good frame passes.
        build_frame(48'h112233445566, 48'h0cc47a88c047, 16'h0800, 16, 1'b1);
        run_frame(1'b0);
        build_frame(LOCAL_MAC, 48'h0cc47a88c047, 16'h0800, 16, 1'b1);
        run_frame(1'b0);

        // Broadcast: accepted by the default instance, dropped by dut_nb.
        build_frame(BCAST, 48'h020000000001, 16'h86dd, 16, 1'b1);
        run_frame(1'b0);

        // 23-byte frame: residual byte emitted from FLUSH, one input bubble.
        bubbles = 0;
        build_frame(LOCAL_MAC, 48'h0cc47a88c047, 16'h0800, 9, 1'b1);
        run_frame(1'b0);
        chk("flush_bubble", bubbles, 1);

        // Runt (exactly 14 bytes), then a normal frame.
        build_frame(LOCAL_MAC, 48'h0cc47a88c047, 16'h0800, 0, 1'b1);
        run_frame(1'b0);
        build_frame(LOCAL_MAC, 48'h0a0b0c0d0e0f, 16'h0806, 21, 1'b0);
        run_frame(1'b0);

        // Output stalled 5 cycles once the first payload flit is out.
        build_frame(LOCAL_MAC, 48'h0cc47a88c047, 16'h0800, 40, 1'b0);
        fork
            run_frame(1'b0);
            begin
                for (int t = 0; t < 200 && !out_valid; t++) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Reset after flit 2 while the first payload flit is pending.
        out_ready = 1'b0;
        build_frame(LOCAL_MAC, 48'h0cc47a88c047, 16'h0800, 30, 1'b1);
        send_flit({frm[7], frm[6], frm[5], frm[4], frm[3], frm[2], frm[1], frm[0]}, 8'hff, 1'b0);
        send_flit({frm[15], frm[14], frm[13], frm[12], frm[11], frm[10], frm[9], frm[8]}, 8'hff, 1'b0);
        send_flit({frm[23], frm[22], frm[21], frm[20], frm[19], frm[18], frm[17], frm[16]}, 8'hff, 1'b0);
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("mid_reset_out", {out_valid, out_data, out_keep, out_last}, '0);
        chk("mid_reset_meta_cnt", {src_mac, ethertype, ok_cnt, drop_cnt, in_ready}, '0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        out_ready = 1'b1;
        rxq.delete();
        exp_ok = 0; exp_drop = 0; nb_exp_ok = 0; nb_exp_drop = 0;
        @(posedge clk); #1;
        build_frame(LOCAL_MAC, 48'h1234567890ab, 16'h0800, 20, 1'b1);
        run_frame(1'b0);

        // Random frames of 1..60 bytes with input gaps and output backpressure.
        bp_en = 1'b1;
        fork
            begin
                while (bp_en) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                for (int f = 0; f < 40; f++) begin
                    L   = $urandom_range(1, 60);
                    rnd = {$urandom, $urandom};
                    build_frame(($urandom_range(0, 9) < 7) ? LOCAL_MAC : rnd[47:0],
                                {$urandom, 16'(f)}, 16'($urandom), (L > 14) ? L - 14 : 0, 1'b0);
                    while (frm.size() > L) void'(frm.pop_back());
                    run_frame(1'b1);
                end
                bp_en = 1'b0;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
